// File: rtl/bcd_time_counter.sv
// bcd_time_counter: MM:SS BCD clock with debounced mode/inc keys and set modes
module bcd_time_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int DB_CNT   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [1:0] mode,
  output logic       tick_1hz,
  output logic       hour_carry
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int DW = DB_CNT > 1 ? $clog2(DB_CNT + 1) : 1;
  typedef enum logic [1:0] {RUN = 2'b00, SET_MIN = 2'b01, SET_SEC = 2'b10} state_t;
  state_t        state;
  logic [PW-1:0] pre;
  logic [1:0]    keys, press;
  logic          last, mode_p, inc_p, run_tick;
  function automatic logic [7:0] inc60(input logic [7:0] v);
    return v[3:0] == 4'd9 ? (v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0})
                          : {v[7:4], v[3:0] + 4'd1};
  endfunction
  assign keys     = {key_inc, key_mode};
  assign mode     = state;
  assign last     = pre == PW'(TICK_DIV - 1);
  assign run_tick = state == RUN && last;
  assign mode_p   = press[0];
  assign inc_p    = press[1] & ~press[0];
  for (genvar k = 0; k < 2; k++) begin : g_key
    logic          s1, s2, acc, pr;
    logic [DW-1:0] cnt;
    assign press[k] = pr;
    // synchronize, then accept a new level after DB_CNT stable cycles; pulse on accepted rise
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        acc <= 1'b0;
        cnt <= '0;
        pr  <= 1'b0;
      end else begin
        s1 <= keys[k];
        s2 <= s1;
        pr <= s2 && !acc && cnt == DW'(DB_CNT - 1);
        if (s2 == acc) cnt <= '0;
        else if (cnt == DW'(DB_CNT - 1)) begin
          acc <= s2;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
  end
  // mode FSM, prescaler and BCD time; a mode press always wins over a simultaneous inc press
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= RUN;
      pre        <= '0;
      sec_bcd    <= 8'h00;
      min_bcd    <= 8'h00;
      tick_1hz   <= 1'b0;
      hour_carry <= 1'b0;
    end else begin
      state      <= mode_p ? (state == RUN ? SET_MIN : state == SET_MIN ? SET_SEC : RUN) : state;
      pre        <= (state == RUN && !last) ? pre + 1'b1 : '0;
      tick_1hz   <= run_tick;
      hour_carry <= run_tick && sec_bcd == 8'h59 && min_bcd == 8'h59;
      if (run_tick) begin
        sec_bcd <= inc60(sec_bcd);
        if (sec_bcd == 8'h59) min_bcd <= inc60(min_bcd);
      end else if (state == SET_MIN && inc_p) min_bcd <= inc60(min_bcd);
      else if (state == SET_SEC && inc_p) sec_bcd <= inc60(sec_bcd);
    end
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed checks of counting, debounce, set modes and reset
module tb_bcd_time_counter;
  logic       clk = 1'b0, rst = 1'b1, key_mode = 1'b0, key_inc = 1'b0;
  logic [7:0] sec_bcd, min_bcd;
  logic [1:0] mode;
  logic       tick_1hz, hour_carry;
  int         n_assert = 0, n_fail = 0, hc_cnt = 0;

  bcd_time_counter #(.TICK_DIV(10), .DB_CNT(4)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .mode(mode),
    .tick_1hz(tick_1hz), .hour_carry(hour_carry)
  );

  always #5 clk = ~clk;

  // count hour_carry pulses seen over the whole run
  always @(negedge clk) if (hour_carry) hc_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i);
    key_mode = m;
    key_inc  = i;
    cyc(8);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    cyc(8);
  endtask

  initial begin
    cyc(2);
    chk("rst_sec", sec_bcd, 8'h00);
    chk("rst_min", min_bcd, 8'h00);
    chk("rst_mode", mode, 2'b00);
    chk("rst_tick", tick_1hz, 1'b0);
    chk("rst_hc", hour_carry, 1'b0);
    rst = 1'b0;
    cyc(9);
    chk("pre_tick_sec", sec_bcd, 8'h00);
    chk("pre_tick_tick", tick_1hz, 1'b0);
    cyc(1);
    chk("first_tick_sec", sec_bcd, 8'h01);
    chk("first_tick_tick", tick_1hz, 1'b1);
    cyc(1);
    chk("tick_one_cycle", tick_1hz, 1'b0);
    cyc(89);
    chk("sec_10", sec_bcd, 8'h10);
    chk("min_00", min_bcd, 8'h00);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    key_mode = 1'b1;
    cyc(3);
    key_mode = 1'b0;
    cyc(11);
    chk("glitch_mode", mode, 2'b00);
    key_mode = 1'b1;
    cyc(6);
    chk("db_not_yet", mode, 2'b00);
    cyc(1);
    chk("db_accepted", mode, 2'b01);
    cyc(1);
    key_mode = 1'b0;
    cyc(12);
    chk("release_mode", mode, 2'b01);
    chk("setmin_frozen_sec", sec_bcd, 8'h02);
    chk("setmin_no_tick", tick_1hz, 1'b0);
    repeat (58) press(1'b0, 1'b1);
    chk("min_58", min_bcd, 8'h58);
    press(1'b0, 1'b1);
    chk("min_59", min_bcd, 8'h59);
    press(1'b0, 1'b1);
    chk("min_wrap_00", min_bcd, 8'h00);
    press(1'b0, 1'b1);
    chk("min_01", min_bcd, 8'h01);
    chk("setmin_sec_kept", sec_bcd, 8'h02);
    chk("setmin_no_hc", hc_cnt, 0);
    repeat (58) press(1'b0, 1'b1);
    chk("min_preload_59", min_bcd, 8'h59);
    press(1'b1, 1'b1);
    chk("both_mode", mode, 2'b10);
    chk("both_min_kept", min_bcd, 8'h59);
    chk("both_sec_kept", sec_bcd, 8'h02);
    repeat (58) press(1'b0, 1'b1);
    chk("sec_wrap_00", sec_bcd, 8'h00);
    chk("sec_wrap_min_kept", min_bcd, 8'h59);
    repeat (59) press(1'b0, 1'b1);
    chk("sec_preload_59", sec_bcd, 8'h59);
    chk("setsec_no_hc", hc_cnt, 0);
    key_mode = 1'b1;
    cyc(7);
    chk("back_to_run", mode, 2'b00);
    cyc(1);
    key_mode = 1'b0;
    cyc(8);
    chk("roll_pre_sec", sec_bcd, 8'h59);
    chk("roll_pre_tick", tick_1hz, 1'b0);
    cyc(1);
    chk("roll_sec", sec_bcd, 8'h00);
    chk("roll_min", min_bcd, 8'h00);
    chk("roll_tick", tick_1hz, 1'b1);
    chk("roll_hc", hour_carry, 1'b1);
    cyc(1);
    chk("roll_tick_end", tick_1hz, 1'b0);
    chk("roll_hc_end", hour_carry, 1'b0);
    cyc(7539);
    chk("t1234_sec", sec_bcd, 8'h34);
    chk("t1234_min", min_bcd, 8'h12);
    chk("t1234_tick", tick_1hz, 1'b1);
    cyc(5);
    key_mode = 1'b1;
    cyc(2);
    rst = 1'b1;
    key_mode = 1'b0;
    #1;
    chk("async_sec", sec_bcd, 8'h00);
    chk("async_min", min_bcd, 8'h00);
    chk("async_mode", mode, 2'b00);
    chk("async_tick", tick_1hz, 1'b0);
    chk("async_hc", hour_carry, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(9);
    chk("post_rst_sec", sec_bcd, 8'h00);
    chk("post_rst_tick", tick_1hz, 1'b0);
    cyc(1);
    chk("post_rst_first_sec", sec_bcd, 8'h01);
    chk("post_rst_first_tick", tick_1hz, 1'b1);
    chk("post_rst_mode", mode, 2'b00);
    cyc(1);
    chk("post_rst_tick_end", tick_1hz, 1'b0);
    chk("hc_total", hc_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per 1 s tick (50 MHz board clock).
REQ-002 SHALL have parameter DB_CNT, default 1000000, meaning the number of consecutive stable clk cycles needed to accept a key level (20 ms).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning an asynchronous, active-high reset.
REQ-005 SHALL have port key_mode, input, 1, meaning the raw, asynchronous, active-high mode button.
REQ-006 SHALL have port key_inc, input, 1, meaning the raw, asynchronous, active-high increment button.
REQ-007 SHALL have port sec_bcd, output, 8, meaning seconds as packed BCD: [7:4] tens, [3:0] units.
REQ-008 SHALL have port min_bcd, output, 8, meaning minutes as packed BCD, feeding the 2-digit display driver data_in.
REQ-009 SHALL have port mode, output, 2, meaning current state: 00 RUN, 01 SET_MIN, 10 SET_SEC.
REQ-010 SHALL have port tick_1hz, output, 1, meaning a one-cycle pulse per elapsed second in RUN.
REQ-011 SHALL have port hour_carry, output, 1, meaning a one-cycle pulse on the 59:59->00:00 rollover.

Function
REQ-012 SHALL pass each key through a 2-FF synchronizer before any other use.
REQ-013 SHALL give each key a debouncer with a counter of at least clog2(DB_CNT+1) bits.
REQ-014 SHALL clear the debounce counter whenever the synced level differs from the accepted level.
REQ-015 SHALL update the accepted level when the synced level stays different for DB_CNT consecutive cycles.
REQ-016 SHALL generate a press event as a one-cycle pulse on the accepted 0->1 transition only; release generates nothing.
REQ-017 SHALL use a prescaler that counts 0..TICK_DIV-1 in RUN only.
REQ-018 SHALL, on the edge where the prescaler equals TICK_DIV-1, reset the prescaler to 0 and increment the time by one second on that same edge.
REQ-019 SHALL assert tick_1hz, registered, for exactly the cycle following that edge.
REQ-020 SHALL wrap the seconds units 9->0 with a carry to the tens.
REQ-021 SHALL wrap the seconds tens 5->0 with a carry to the minutes units.
REQ-022 SHALL give the minutes the same 0-9 units and 0-5 tens rules.
REQ-023 SHALL, at 59:59, roll the time to 00:00 and pulse hour_carry in the same cycle as tick_1hz.
REQ-024 SHALL never output a nibble value above 9 or a tens digit above 5.
REQ-025 SHALL advance the state machine on a mode press: RUN->SET_MIN->SET_SEC->RUN.
REQ-026 SHALL hold the prescaler at 0 and suppress tick_1hz and hour_carry in SET_MIN and SET_SEC.
REQ-027 SHALL, in SET_MIN, increment minutes by one per inc press, wrapping 59->00 with no carry and no hour_carry.
REQ-028 SHALL, in SET_SEC, increment seconds by one per inc press, wrapping 59->00 with no carry into minutes.
REQ-029 SHALL ignore inc presses in RUN.
REQ-030 SHALL, when mode and inc press events occur in the same cycle, take the mode transition and discard the inc event.
REQ-031 SHALL, on re-entering RUN, start the prescaler from 0 so the first tick comes TICK_DIV cycles after the transition edge.
REQ-032 SHALL drive all outputs from registers, except mode, which SHALL equal the state register directly.

Reset
REQ-033 SHALL, while rst=1, immediately force sec_bcd=8'h00, min_bcd=8'h00, mode=00, tick_1hz=0, hour_carry=0.
REQ-034 SHALL, while rst=1, force the prescaler and debounce counters to 0, synchronizers to 0 and accepted key levels to 0.
REQ-035 SHALL, when rst asserts mid-count or mid-debounce, abort all activity with no residual press or tick pulse after release.
REQ-036 SHALL resume counting on the first clk edge after rst deasserts.

Verification (TICK_DIV=10, DB_CNT=4)
REQ-037 SHALL cover: rst released, 10 clk in RUN -> sec_bcd=8'h01, tick_1hz high 1 cycle; after 100 clk -> sec_bcd=8'h10.
REQ-038 SHALL cover: preload 59:59 via set mode, return to RUN, wait 10 clk -> min_bcd=8'h00, sec_bcd=8'h00, hour_carry and tick_1hz pulse together.
REQ-039 SHALL cover: key_mode high 3 cycles then low -> no state change; high 8 cycles -> mode=01 exactly once, release adds no event.
REQ-040 SHALL cover: SET_MIN at min 58, three inc presses -> min_bcd 59, 00, 01; sec_bcd unchanged; no hour_carry.
REQ-041 SHALL cover: key_mode and key_inc rising together in SET_MIN -> mode=10, minutes unchanged.
REQ-042 SHALL cover: rst pulsed at prescaler 7 with time 12:34 -> outputs 00:00, mode 00 immediately; first tick 10 clk after release.
